// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  // Instruction returned for out-of-range fetches (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Upper bound on the grant-to-valid delay the delay line supports.
  localparam int MAX_LATENCY = 4;

  // One slot of the response delay line.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } imem_resp_t;

  localparam imem_resp_t RESP_IDLE = '{valid: 1'b0, err: 1'b0, data: 32'h0};

  // Build a valid response; out-of-range reads are replaced by a NOP.
  function automatic imem_resp_t make_resp(input logic oob, input logic [31:0] word);
    imem_resp_t r;
    r.valid = 1'b1;
    r.err   = oob;
    r.data  = oob ? NOP_INSTR : word;
    return r;
  endfunction

endpackage

// File: rtl/imem_delay_line.sv
// Fixed-length shift register carrying responses from the read to the
// output. Payload only advances behind a valid entry, so the tail keeps
// the most recently delivered word while the line is idle.
module imem_delay_line
  import imem_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  imem_resp_t resp_in,
  output imem_resp_t resp_out
);

  imem_resp_t stage_q [STAGES];

  // Shift every slot one step per cycle; async clear drops everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESP_IDLE;
      end
    end else begin
      // Stage 0: freshly read word enters the line.
      stage_q[0].valid <= resp_in.valid;
      if (resp_in.valid) begin
        stage_q[0].err  <= resp_in.err;
        stage_q[0].data <= resp_in.data;
      end
      // Stages 1..STAGES-1: move toward the output.
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i].valid <= stage_q[i-1].valid;
        if (stage_q[i-1].valid) begin
          stage_q[i].err  <= stage_q[i-1].err;
          stage_q[i].data <= stage_q[i-1].data;
        end
      end
    end
  end

  assign resp_out = stage_q[STAGES-1];

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction-memory responder: grants fetch requests, reads a word from
// the local array and returns it a fixed number of cycles later, in order.
// A side port preloads the array; its contents survive reset.
module instr_mem_resp
  import imem_pkg::*;
#(
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_in,
  input  logic [31:0] instr_addr_in,
  input  logic        gnt_stall_in,
  output logic        gnt_out,
  output logic        instr_rvalid_out,
  output logic [31:0] instr_rdata_out,
  output logic        err_out,
  input  logic        load_we_in,
  input  logic [31:0] load_addr_in,
  input  logic [31:0] load_data_in
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
  localparam logic [31:0] DEPTH_C   = 32'(DEPTH);

  // Reject parameter combinations the delay line and counter cannot honour.
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("instr_mem_resp: LATENCY must be in 1..%0d", MAX_LATENCY);
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY) begin : g_bad_outstanding
    $error("instr_mem_resp: MAX_OUTSTANDING must be in 1..LATENCY");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("instr_mem_resp: DEPTH must be at least 2");
  end

  // Counter step that can neither pass the limit nor wrap below zero.
  function automatic logic [CW-1:0] count_next(input logic [CW-1:0] cur,
                                               input logic          inc,
                                               input logic          dec);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != MAX_OUT_C) begin
      nxt = cur + CW'(1);
    end else if (dec && !inc && cur != '0) begin
      nxt = cur - CW'(1);
    end
    return nxt;
  endfunction

  logic [31:0]   mem [DEPTH];
  logic [CW-1:0] outstanding;
  logic          accept;
  logic          rsp_fire;
  logic          rd_oob;
  logic          ld_oob;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] ld_idx;
  imem_resp_t    resp_p0;
  imem_resp_t    resp_tail;

  // Full 32-bit range compare: high address bits never alias into the array.
  assign rd_oob   = (instr_addr_in >= DEPTH_C);
  assign ld_oob   = (load_addr_in  >= DEPTH_C);
  assign rd_idx   = instr_addr_in[AW-1:0];
  assign ld_idx   = load_addr_in[AW-1:0];
  assign rsp_fire = resp_tail.valid;

  // Grant while a slot is free, counting the slot released by this cycle's response.
  always_comb begin
    gnt_out = reset && !gnt_stall_in && ((outstanding < MAX_OUT_C) || rsp_fire);
    accept  = instr_req_in && gnt_out;
  end

  // Read the array for an accepted request; this is the entry into the delay line.
  always_comb begin
    resp_p0 = RESP_IDLE;
    if (accept) begin
      resp_p0 = make_resp(rd_oob, rd_oob ? 32'h0 : mem[rd_idx]);
    end
  end

  // Track granted-but-unreturned requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      outstanding <= count_next(outstanding, accept, rsp_fire);
    end
  end

  // Preload port; no reset so programs survive a core reset. A read accepted
  // on the same edge sees the previous contents.
  always_ff @(posedge clk) begin
    if (load_we_in && !ld_oob) begin
      mem[ld_idx] <= load_data_in;
    end
  end

  imem_delay_line #(
    .STAGES (LATENCY)
  ) u_delay_line (
    .clk      (clk),
    .reset    (reset),
    .resp_in  (resp_p0),
    .resp_out (resp_tail)
  );

  // Drive the response port straight from the last delay stage.
  always_comb begin
    instr_rvalid_out = resp_tail.valid;
    instr_rdata_out  = resp_tail.data;
    err_out          = resp_tail.err;
  end

endmodule

// File: tb/tb_instr_mem_resp.sv
// Scoreboard bench for instr_mem_resp: one instance with two outstanding
// slots and one limited to a single outstanding request.
module tb_instr_mem_resp;
  import imem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, stall0, gnt0, rv0, err0;
  logic [31:0] addr0, rd0;
  logic        req1, stall1, gnt1, rv1, err1;
  logic [31:0] addr1, rd1;
  logic        load_we;
  logic [31:0] load_addr, load_data;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] shadow [DEPTH];
  logic [31:0] last0, last1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  instr_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(2)) u_dut (
    .clk(clk), .reset(reset),
    .instr_req_in(req0), .instr_addr_in(addr0), .gnt_stall_in(stall0),
    .gnt_out(gnt0), .instr_rvalid_out(rv0), .instr_rdata_out(rd0), .err_out(err0),
    .load_we_in(load_we), .load_addr_in(load_addr), .load_data_in(load_data)
  );

  instr_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(1)) u_dut_m1 (
    .clk(clk), .reset(reset),
    .instr_req_in(req1), .instr_addr_in(addr1), .gnt_stall_in(stall1),
    .gnt_out(gnt1), .instr_rvalid_out(rv1), .instr_rdata_out(rd1), .err_out(err1),
    .load_we_in(load_we), .load_addr_in(load_addr), .load_data_in(load_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input int due);
    exp_t e;
    e.due = due;
    if (a >= 32'(DEPTH)) begin
      e.data = 32'h0000_0013;
      e.err  = 1'b1;
    end else begin
      e.data = shadow[a[9:0]];
      e.err  = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Negedge monitor: compare responses, then record accepts, then mirror preloads.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q0.delete();
      q1.delete();
      last0 = 32'h0;
      last1 = 32'h0;
      check("rst_gnt", {31'h0, gnt0}, 32'h0);
      check("rst_rvalid", {31'h0, rv0}, 32'h0);
      check("rst_rdata", rd0, 32'h0);
      check("rst_err", {31'h0, err0}, 32'h0);
      check("rst_rvalid_m1", {31'h0, rv1}, 32'h0);
    end else begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        e = q0.pop_front();
        check("rvalid", {31'h0, rv0}, 32'h1);
        check("rdata", rd0, e.data);
        check("err", {31'h0, err0}, {31'h0, e.err});
        last0 = e.data;
      end else begin
        check("rvalid_idle", {31'h0, rv0}, 32'h0);
        check("rdata_hold", rd0, last0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        check("m1_rvalid", {31'h0, rv1}, 32'h1);
        check("m1_rdata", rd1, e.data);
        last1 = e.data;
      end else begin
        check("m1_rvalid_idle", {31'h0, rv1}, 32'h0);
        check("m1_rdata_hold", rd1, last1);
      end
      if (req0 && gnt0) q0.push_back(model(addr0, cyc + LAT));
      if (req1 && gnt1) q1.push_back(model(addr1, cyc + LAT));
    end
    if (load_we && load_addr < 32'(DEPTH)) shadow[load_addr[9:0]] = load_data;
  end

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  // Fetch n consecutive words from base, holding req until each is granted.
  task automatic fetch_seq(input logic [31:0] base, input int n, output int used);
    int acc = 0;
    used = 0;
    req0 = 1'b1; addr0 = base;
    while (acc < n && used < 200) begin
      @(negedge clk);
      if (gnt0) acc++;
      @(posedge clk); #1;
      addr0 = base + 32'(acc);
      used++;
    end
    req0 = 1'b0;
    check("fetch_done", 32'(acc), 32'(n));
  endtask

  task automatic drain();
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    int acc;
    reset = 1'b0;
    req0 = 1'b0; addr0 = '0; stall0 = 1'b0;
    req1 = 1'b0; addr1 = '0; stall1 = 1'b0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Program image: words 0..3 = 11,22,33,44; word 7 = 55; the rest distinct.
    for (int i = 0; i < 16; i++) begin
      if (i < 4)       load_word(32'(i), 32'(i + 1) * 32'h11);
      else if (i == 7) load_word(32'(i), 32'h55);
      else             load_word(32'(i), 32'h1000 + 32'(i));
    end
    load_word(32'd1029, 32'hDEAD_BEEF);  // out of range, must not alias to word 5

    // Back-to-back burst: four grants in four cycles.
    fetch_seq(32'd0, 4, used);
    check("burst_cycles", 32'(used), 32'd4);
    drain();

    // Single outstanding slot: grant every other cycle.
    acc = 0;
    req1 = 1'b1; addr1 = 32'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("m1_gnt_pattern", {31'h0, gnt1}, (k % 2 == 0) ? 32'h1 : 32'h0);
      if (gnt1) acc++;
      @(posedge clk); #1;
      addr1 = 32'(acc % 4);
    end
    req1 = 1'b0;
    drain();

    // Out-of-range fetches followed by in-range ones.
    fetch_seq(32'd1024, 1, used);
    fetch_seq(32'd5, 1, used);
    fetch_seq(32'h0001_0005, 1, used);
    fetch_seq(32'd1029, 1, used);
    fetch_seq(32'd5, 1, used);
    drain();

    // Wait-state injection in the middle of a held request stream.
    acc = 0;
    req0 = 1'b1; addr0 = 32'd8;
    for (int k = 0; k < 12 && acc < 8; k++) begin
      stall0 = (k >= 2 && k < 5);
      @(negedge clk);
      if (stall0) check("stall_gnt", {31'h0, gnt0}, 32'h0);
      if (gnt0) acc++;
      @(posedge clk); #1;
      addr0 = 32'd8 + 32'(acc);
    end
    stall0 = 1'b0; req0 = 1'b0;
    check("stall_stream_count", 32'(acc), 32'd8);
    drain();

    // Reset with two requests in flight: their responses must never appear.
    req0 = 1'b1; addr0 = 32'd2;
    @(negedge clk); check("pre_rst_gnt_a", {31'h0, gnt0}, 32'h1);
    @(posedge clk); #1 addr0 = 32'd3;
    @(negedge clk); check("pre_rst_gnt_b", {31'h0, gnt0}, 32'h1);
    @(posedge clk); #1;
    req0 = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    fetch_seq(32'd0, 4, used);
    check("post_rst_burst_cycles", 32'(used), 32'd4);
    drain();

    // Preload and fetch of the same word on the same edge.
    load_we = 1'b1; load_addr = 32'd7; load_data = 32'hAA;
    req0 = 1'b1; addr0 = 32'd7;
    @(negedge clk); check("same_edge_gnt", {31'h0, gnt0}, 32'h1);
    @(posedge clk); #1;
    load_we = 1'b0; req0 = 1'b0;
    drain();
    fetch_seq(32'd7, 1, used);
    drain();

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
